// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types, widths and address helper for the ram slave
package ram_pkg;
    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } ram_state_t;

    // Upper address bits and the byte offset are dropped, so addresses alias.
    function automatic logic [31:0] word_index(input logic [31:0] byte_addr, input int addr_bits);
        logic [31:0] mask;
        mask = (32'd1 << addr_bits) - 32'd1;
        return (byte_addr & mask) >> 2;
    endfunction
endpackage

// File: rtl/ram_byte_lane_merge.sv
// rtl/ram_byte_lane_merge.sv - merge new write data into an old word under byte enables
module ram_byte_lane_merge
    import ram_pkg::*;
#(
    parameter int W  = WORD_W,
    parameter int BE = BE_W
) (
    input  logic [W-1:0]  old_word,
    input  logic [W-1:0]  new_word,
    input  logic [BE-1:0] be,
    output logic [W-1:0]  merged
);
    always_comb begin
        merged = old_word;
        for (int b = 0; b < BE; b++) begin
            if (be[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
        end
    end
endmodule

// File: rtl/ram.sv
// rtl/ram.sv - byte-enabled word memory, Avalon-MM slave with a level-sensitive preload port
module ram
    import ram_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int WORD_BITS = WORD_W
) (
    input  logic                   clk,
    input  logic                   RAM_Reset,
    input  logic [31:0]            address,
    input  logic                   write,
    input  logic                   read,
    output logic                   waitrequest,
    input  logic [WORD_BITS-1:0]   writedata,
    input  logic [WORD_BITS/8-1:0] byteenable,
    output logic [WORD_BITS-1:0]   readdata,
    input  logic [WORD_BITS-1:0]   instruction,
    input  logic                   inst_input,
    input  logic [7:0]             inst_addr
);
    localparam int IDX_W = ADDR_BITS - 2;
    localparam int WORDS = 2 ** IDX_W;

    logic [WORD_BITS-1:0] bus_mem [WORDS];
    logic [WORD_BITS-1:0] pre_mem [WORDS];
    logic [WORDS-1:0]     pre_sel;
    logic [WORDS-1:0]     clr_q;
    logic [IDX_W-1:0]     bus_idx;
    logic [IDX_W-1:0]     inst_idx;
    logic                 pre_active;
    logic                 commit;
    logic                 do_commit;
    logic [WORD_BITS-1:0] cur_word;
    logic [WORD_BITS-1:0] merged_word;
    ram_state_t           state_q;
    ram_state_t           state_d;

    assign bus_idx    = IDX_W'(word_index(address, ADDR_BITS));
    assign inst_idx   = IDX_W'(word_index({24'd0, inst_addr}, ADDR_BITS));
    assign pre_active = inst_input && !RAM_Reset;
    assign do_commit  = commit && !(pre_active && (inst_idx == bus_idx));

    // Preloaded words live in a transparent latch array so sub-cycle updates are all kept.
    always_latch begin
        for (int i = 0; i < WORDS; i++) begin
            if (pre_active && (inst_idx == IDX_W'(i))) pre_mem[i] = instruction;
        end
    end

    // pre_sel marks words whose newest value came from preload; a bus write hands ownership back.
    always_latch begin
        for (int i = 0; i < WORDS; i++) begin
            if (RAM_Reset) begin
                pre_sel[i] = 1'b0;
            end else if (inst_input && (inst_idx == IDX_W'(i))) begin
                pre_sel[i] = 1'b1;
            end else if (clr_q[i]) begin
                pre_sel[i] = 1'b0;
            end
        end
    end

    always_comb begin
        cur_word = pre_sel[bus_idx] ? pre_mem[bus_idx] : bus_mem[bus_idx];
    end

    ram_byte_lane_merge #(
        .W  (WORD_BITS),
        .BE (WORD_BITS / 8)
    ) u_merge (
        .old_word (cur_word),
        .new_word (writedata),
        .be       (byteenable),
        .merged   (merged_word)
    );

    always_comb begin
        state_d     = IDLE;
        waitrequest = 1'b0;
        readdata    = '0;
        commit      = 1'b0;
        if (RAM_Reset) begin
            waitrequest = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (read || write) begin
                        waitrequest = 1'b1;
                        state_d     = ACK;
                    end
                end
                ACK: begin
                    if (write) commit = 1'b1;
                    else if (read) readdata = cur_word;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (RAM_Reset) begin
            state_q <= IDLE;
            clr_q   <= '0;
            for (int i = 0; i < WORDS; i++) bus_mem[i] <= '0;
        end else begin
            state_q <= state_d;
            clr_q   <= '0;
            if (do_commit) begin
                bus_mem[bus_idx] <= merged_word;
                clr_q[bus_idx]   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ram.sv
// tb/tb_ram.sv - directed self-checking bench for the ram slave
module tb_ram;
    logic        clk = 1'b0;
    logic        RAM_Reset;
    logic [31:0] address;
    logic        write;
    logic        read;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic [31:0] instruction;
    logic        inst_input;
    logic [7:0]  inst_addr;

    int total = 0;
    int bad   = 0;

    logic [31:0] r_d;
    int          r_w;
    bit          r_to;

    ram dut (
        .clk         (clk),
        .RAM_Reset   (RAM_Reset),
        .address     (address),
        .write       (write),
        .read        (read),
        .waitrequest (waitrequest),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .readdata    (readdata),
        .instruction (instruction),
        .inst_input  (inst_input),
        .inst_addr   (inst_addr)
    );

    always #5 clk = ~clk;

    // Called at posedge+1 with the FSM idle; returns completion data, wait count, timeout flag.
    task automatic bus_access(input bit is_wr, input bit is_rd, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be);
        bit done;
        done       = 0;
        r_w        = 0;
        r_d        = 'x;
        address    = addr;
        write      = is_wr;
        read       = is_rd;
        writedata  = wdata;
        byteenable = be;
        for (int c = 0; c < 8 && !done; c++) begin
            @(negedge clk);
            if (waitrequest) r_w++;
            else begin
                r_d  = readdata;
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        read  = 0;
        write = 0;
        r_to  = !done;
    endtask

    task automatic test_reset;
        RAM_Reset = 1;
        @(negedge clk);
        total++;
        if (waitrequest !== 1'b1) begin
            bad++;
            $display("FAIL reset_wait got=%b exp=1", waitrequest);
        end
        total++;
        if (readdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_rdata got=%h exp=00000000", readdata);
        end
        @(posedge clk);
        #1;
        RAM_Reset = 0;
        bus_access(0, 1, 32'h04, 32'h0, 4'h0);
        total++;
        if (r_to || r_w !== 1 || r_d !== 32'h0) begin
            bad++;
            $display("FAIL reset_clear got=%h waits=%0d to=%0b exp=00000000 waits=1", r_d, r_w, r_to);
        end
    endtask

    task automatic test_preload;
        logic [31:0] words [6];
        words = '{32'h240C0010, 32'h08000005, 32'h24420020, 32'h24420030, 32'h00000040, 32'h00000008};
        inst_input = 1;
        for (int i = 0; i < 6; i++) begin
            inst_addr   = 8'(4 * (i + 1));
            instruction = words[i];
            #1;
        end
        inst_input = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            bus_access(0, 1, 32'(4 * (i + 1)), 32'h0, 4'h0);
            total++;
            if (r_to || r_w !== 1 || r_d !== words[i]) begin
                bad++;
                $display("FAIL preload_fetch_%0d got=%h waits=%0d exp=%h waits=1", i, r_d, r_w, words[i]);
            end
        end
    endtask

    task automatic test_byte_enable;
        bus_access(1, 0, 32'h20, 32'hAABBCCDD, 4'b1111);
        total++;
        if (r_to || r_w !== 1 || r_d !== 32'h0) begin
            bad++;
            $display("FAIL be_write_rdata got=%h waits=%0d exp=00000000 waits=1", r_d, r_w);
        end
        bus_access(1, 0, 32'h20, 32'h11223344, 4'b0101);
        bus_access(0, 1, 32'h20, 32'h0, 4'h0);
        total++;
        if (r_to || r_d !== 32'hAA22CC44) begin
            bad++;
            $display("FAIL be_merge got=%h exp=AA22CC44", r_d);
        end
    endtask

    task automatic test_alias;
        bus_access(1, 0, 32'hBFC00004, 32'hDEADBEEF, 4'hF);
        bus_access(0, 1, 32'h04, 32'h0, 4'h0);
        total++;
        if (r_to || r_d !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL alias_low got=%h exp=DEADBEEF", r_d);
        end
        bus_access(0, 1, 32'h0000_0107, 32'h0, 4'h0);
        total++;
        if (r_to || r_d !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL alias_high got=%h exp=DEADBEEF", r_d);
        end
    endtask

    task automatic test_abort;
        address    = 32'h20;
        writedata  = 32'h0;
        byteenable = 4'hF;
        write      = 1;
        @(negedge clk);
        total++;
        if (waitrequest !== 1'b1) begin
            bad++;
            $display("FAIL abort_wait got=%b exp=1", waitrequest);
        end
        @(posedge clk);
        #1;
        write = 0;
        @(negedge clk);
        total++;
        if (waitrequest !== 1'b0 || readdata !== 32'h0) begin
            bad++;
            $display("FAIL abort_ack got wait=%b rdata=%h exp wait=0 rdata=00000000", waitrequest, readdata);
        end
        @(posedge clk);
        #1;
        bus_access(0, 1, 32'h20, 32'h0, 4'h0);
        total++;
        if (r_to || r_w !== 1 || r_d !== 32'hAA22CC44) begin
            bad++;
            $display("FAIL abort_keep got=%h waits=%0d exp=AA22CC44 waits=1", r_d, r_w);
        end
    endtask

    task automatic test_rw_both;
        bus_access(1, 1, 32'h28, 32'h0BADF00D, 4'hF);
        total++;
        if (r_to || r_w !== 1 || r_d !== 32'h0) begin
            bad++;
            $display("FAIL rw_both_rdata got=%h waits=%0d exp=00000000 waits=1", r_d, r_w);
        end
        bus_access(1, 0, 32'h28, 32'hFFFFFFFF, 4'h0);
        bus_access(0, 1, 32'h28, 32'h0, 4'h0);
        total++;
        if (r_to || r_d !== 32'h0BADF00D) begin
            bad++;
            $display("FAIL rw_both_be0 got=%h exp=0BADF00D", r_d);
        end
    endtask

    task automatic test_preload_in_ack;
        address = 32'h30;
        read    = 1;
        @(posedge clk);
        #1;
        inst_addr   = 8'h30;
        instruction = 32'hCAFEF00D;
        inst_input  = 1;
        @(negedge clk);
        total++;
        if (waitrequest !== 1'b0 || readdata !== 32'hCAFEF00D) begin
            bad++;
            $display("FAIL preload_ack got wait=%b rdata=%h exp wait=0 rdata=CAFEF00D", waitrequest, readdata);
        end
        @(posedge clk);
        #1;
        read       = 0;
        inst_input = 0;
        instruction = 32'h0;
        bus_access(0, 1, 32'h30, 32'h0, 4'h0);
        total++;
        if (r_to || r_d !== 32'hCAFEF00D) begin
            bad++;
            $display("FAIL preload_retain got=%h exp=CAFEF00D", r_d);
        end
    endtask

    task automatic test_reset_mid;
        address    = 32'h24;
        writedata  = 32'h12345678;
        byteenable = 4'hF;
        write      = 1;
        @(posedge clk);
        #1;
        RAM_Reset = 1;
        @(negedge clk);
        total++;
        if (waitrequest !== 1'b1 || readdata !== 32'h0) begin
            bad++;
            $display("FAIL midreset_out got wait=%b rdata=%h exp wait=1 rdata=00000000", waitrequest, readdata);
        end
        @(posedge clk);
        #1;
        RAM_Reset = 0;
        write     = 0;
        @(negedge clk);
        total++;
        if (waitrequest !== 1'b0) begin
            bad++;
            $display("FAIL midreset_idle got=%b exp=0", waitrequest);
        end
        @(posedge clk);
        #1;
        bus_access(0, 1, 32'h24, 32'h0, 4'h0);
        total++;
        if (r_to || r_w !== 1 || r_d !== 32'h0) begin
            bad++;
            $display("FAIL midreset_word got=%h waits=%0d exp=00000000 waits=1", r_d, r_w);
        end
        bus_access(0, 1, 32'h30, 32'h0, 4'h0);
        total++;
        if (r_to || r_d !== 32'h0) begin
            bad++;
            $display("FAIL midreset_preload_clr got=%h exp=00000000", r_d);
        end
    endtask

    initial begin
        RAM_Reset   = 1;
        address     = 0;
        write       = 0;
        read        = 0;
        writedata   = 0;
        byteenable  = 0;
        instruction = 0;
        inst_input  = 0;
        inst_addr   = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_preload();
        test_byte_enable();
        test_alias();
        test_abort();
        test_rw_both();
        test_preload_in_ack();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ram.md
Name: ram

Overview:
- Word-organised, byte-enabled memory acting as an Avalon-MM slave for the CPU (top_level_CPU), which is the bus master.
- Includes a side-band preload port so a bench can write instruction words into memory before the CPU fetches.
- One clock domain; synchronous, active-high memory reset.

Parameters:
- ADDR_BITS, 8, number of byte-address bits decoded. Gives 2^ADDR_BITS bytes, i.e. 64 words at the default.
- WORD_BITS, 32, data word width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge except the preload path.
- RAM_Reset  in  1  synchronous, active-high reset.
- address  in  32  byte address from the master; the word index is address[ADDR_BITS-1:2]; the upper bits and [1:0] are ignored, so addresses alias.
- write  in  1  Avalon write request.
- read  in  1  Avalon read request.
- waitrequest  out  1  Avalon stall; the master holds its request while this is high.
- writedata  in  32  write data.
- byteenable  in  4  write lane enables; bit0 selects bits[7:0] (little-endian lanes).
- readdata  out  32  read data, valid in the cycle where read=1 and waitrequest=0.
- instruction  in  32  preload data word.
- inst_input  in  1  preload enable.
- inst_addr  in  8  preload byte address; the word index is inst_addr[ADDR_BITS-1:2].

Behaviour:
- Storage is an array of 2^(ADDR_BITS-2) 32-bit words.
- Reset:
  - RAM_Reset=1 at a rising edge clears every word to 0 and puts the FSM in IDLE.
  - While RAM_Reset=1, waitrequest=1 and readdata=0.
  - Reset asserted mid-access aborts the access; a pending write is not performed.
- Preload path:
  - While inst_input=1 and RAM_Reset=0, mem[inst_addr index] continuously follows instruction. This path is level-sensitive and not clocked, so words changing every 1 time unit (shorter than a clock period) are all captured.
  - When inst_input falls, the last value is retained.
  - Preload has priority over a bus write to the same word in the same cycle.
  - Preload is only intended while the CPU is held in reset.
- Bus FSM has two states, IDLE and ACK:
  - IDLE: if read or write is asserted, waitrequest=1 (combinational) and next state is ACK. Otherwise waitrequest=0.
  - ACK: waitrequest=0.
    - If read: readdata = mem[index] (combinational from the array).
    - If write: each enabled byte lane of writedata is stored at the rising edge that ends ACK; disabled lanes keep their old value.
    - Next state is always IDLE.
  - Each access therefore takes exactly 2 cycles (1 wait + 1 completion). Back-to-back accesses repeat the pattern with no idle cycle forced between them.
  - If the request drops while in ACK, the access is abandoned, nothing is written, and the FSM returns to IDLE.
  - read and write both high: write wins and readdata=0.
  - byteenable=0 on a write completes the handshake and changes nothing.
  - readdata=0 whenever the FSM is not completing a read.
- A read of a word in the same ACK cycle as a preload to that word returns the preloaded value.

Decomposition:
- Shared package ram_pkg holds:
  - WORD_W=32, BE_W=4
  - state enum ram_state_t {IDLE, ACK}
  - a helper function computing the word index from a byte address
- Natural sub-module: ram_byte_lane_merge, which merges writedata into the old word under byteenable (purely combinational).
- The FSM and array stay in ram.

Test Plan:
- Reset clears: hold RAM_Reset 1 cycle, then read 0x04 -> waitrequest 1 for 1 cycle, then readdata=0x00000000.
- Preload then fetch:
  - Stimulus: inst_input=1; load 0x04=0x240C0010, 0x08=0x08000005, 0x0C=0x24420020, 0x10=0x24420030, 0x14=0x00000040, 0x18=0x00000008 at 1-time-unit spacing; then inst_input=0.
  - Response: bus reads of 0x04 through 0x18 return exactly those words, each after 1 wait cycle.
- Byte-enable write: write 0x20 = 0xAABBCCDD with byteenable=4'b1111, then 0x11223344 with byteenable=4'b0101 -> read 0x20 returns 0xAA22CC44.
- Aliasing: write 0xBFC00004 = 0xDEADBEEF -> read 0x04 returns 0xDEADBEEF.
- Abort and simultaneous requests:
  - Write request dropped in ACK -> word unchanged.
  - read and write high together -> write performed, readdata=0.
- Reset mid-access: assert RAM_Reset in the ACK cycle of a write of 0x12345678 to 0x24 -> read 0x24 returns 0; FSM is in IDLE after reset.
